nes_joypad_reader: RTL and testbench

Parametrised serial controller-port reader for the NES core. It generates the latch and clock strobes for one or more shift-register joypads and deserialises their data lines into parallel button words. Words are presented to the rest of the console with a one-cycle valid strobe. Polls run on demand or automatically at a fixed interval. It sits between the board's controller pins and the CPU-side `$4016/$4017` register logic.

---
 rtl/nes_joypad_reader_pkg.sv | 14 +
 rtl/nes_joypad_shift.sv | 33 +++
 rtl/nes_joypad_reader.sv | 141 ++++++++++++++
 tb/tb_nes_joypad_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_joypad_reader_pkg.sv
// Shared definitions for the NES controller-port reader: FSM states and default strobe timing.
package nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_LOW   = 2'd2,
    ST_HIGH  = 2'd3
  } joy_state_e;

  localparam int NES_JOY_HALF = 300;
  localparam int NES_JOY_BITS = 8;

endpackage

// File: rtl/nes_joypad_shift.sv
// One controller port: 2-FF synchroniser on the serial line and an indexed capture register.
// Captured bits are inverted on the way in so the register holds 1 = pressed.
module nes_joypad_shift #(
  parameter int BITS = 8,
  parameter int IW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_i,
  input  logic            we_i,
  input  logic [IW-1:0]   idx_i,
  output logic [BITS-1:0] cap_o
);

  logic            sync1_q;
  logic            sync2_q;
  logic [BITS-1:0] cap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cap_q   <= '0;
    end else begin
      sync1_q <= data_i;
      sync2_q <= sync1_q;
      if (we_i) cap_q[idx_i] <= ~sync2_q;
    end
  end

  assign cap_o = cap_q;

endmodule

// File: rtl/nes_joypad_reader.sv
// Serial joypad poller: drives shared latch/clock strobes, deserialises NUM_PADS data lines and
// publishes the whole button word with a one-cycle valid strobe, on demand or at a fixed interval.
module nes_joypad_reader
  import nes_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int BITS     = NES_JOY_BITS,
  parameter int HALF     = NES_JOY_HALF,
  parameter int POLL_GAP = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_auto_en,
  input  logic [NUM_PADS-1:0]      i_data,
  output logic                     o_latch,
  output logic                     o_pclk,
  output logic                     o_busy,
  output logic [NUM_PADS*BITS-1:0] o_buttons,
  output logic                     o_valid
);

  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int CW = $clog2(2 * HALF);
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [IW-1:0] BIT_LAST   = IW'(BITS - 1);
  localparam logic [GW-1:0] GAP_END    = GW'(POLL_GAP);

  joy_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             bit_q, bit_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      valid_q, valid_d;
  logic                      latch_q, pclk_q, busy_q;
  logic [NUM_PADS*BITS-1:0]  btn_q;
  logic [NUM_PADS*BITS-1:0]  cap_all;
  logic                      cap_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    cap_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start || (i_auto_en && gap_q == GAP_END)) begin
          state_d = ST_LATCH;
          cnt_d   = LATCH_LAST;
        end else if (gap_q != GAP_END) begin
          // Saturates so a later auto enable polls straight away.
          gap_d = gap_q + GW'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = HALF_LAST;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = HALF_LAST;
          cap_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
            gap_d   = '0;
          end else begin
            state_d = ST_LOW;
            cnt_d   = HALF_LAST;
            bit_d   = bit_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the pins are glitch-free flop outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      latch_q <= (state_d == ST_LATCH);
      pclk_q  <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
      valid_q <= valid_d;
      if (valid_d) btn_q <= cap_all;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    nes_joypad_shift #(
      .BITS (BITS),
      .IW   (IW)
    ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .data_i (i_data[p]),
      .we_i   (cap_we),
      .idx_i  (bit_q),
      .cap_o  (cap_all[p*BITS +: BITS])
    );
  end

  assign o_latch   = latch_q;
  assign o_pclk    = pclk_q;
  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_buttons = btn_q;

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Bench for nes_joypad_reader: a 2-pad NES instance and a 1-pad 16-bit instance, driven by pad
// models that react to the strobes, checked every cycle against a timing-formula model.
module tb_nes_joypad_reader;

  localparam int H   = 2;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start_v = 2'b00;
  logic [1:0]  auto_v  = 2'b00;
  logic [1:0]  data_a  = 2'b11;
  logic [0:0]  data_b  = 1'b1;
  logic [1:0]  lat_v, pck_v, bsy_v, vld_v;
  logic [15:0] btn_v [2];

  always #5 clk = ~clk;

  nes_joypad_reader #(.NUM_PADS(2), .BITS(8), .HALF(H), .POLL_GAP(GAP)) dut_nes (
    .clk(clk), .rst(rst), .i_start(start_v[0]), .i_auto_en(auto_v[0]), .i_data(data_a),
    .o_latch(lat_v[0]), .o_pclk(pck_v[0]), .o_busy(bsy_v[0]), .o_buttons(btn_v[0]),
    .o_valid(vld_v[0]));

  nes_joypad_reader #(.NUM_PADS(1), .BITS(16), .HALF(H), .POLL_GAP(GAP)) dut_snes (
    .clk(clk), .rst(rst), .i_start(start_v[1]), .i_auto_en(auto_v[1]), .i_data(data_b),
    .o_latch(lat_v[1]), .o_pclk(pck_v[1]), .o_busy(bsy_v[1]), .o_buttons(btn_v[1]),
    .o_valid(vld_v[1]));

  function automatic int nbits(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int npads(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Pressed-button masks per instance, laid out like o_buttons.
  logic [15:0] mask [2] = '{16'h0000, 16'h0000};

  // Model state: a poll sampled in cycle t0 occupies cycles t0+1 .. t0+T, valid at t0+T+1.
  bit          active [2] = '{1'b0, 1'b0};
  int          t0     [2] = '{0, 0};
  int          gap    [2] = '{0, 0};
  bit          mvld   [2] = '{1'b0, 1'b0};
  logic [15:0] mbtn   [2] = '{16'h0, 16'h0};
  logic [15:0] pred   [2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int T;
      T = 2 * H * (nbits(i) + 1);
      mvld[i] = 1'b0;
      if (!rst) begin
        active[i] = 1'b0;
        gap[i]    = 0;
        mbtn[i]   = 16'h0;
      end else if (active[i]) begin
        if (cyc - t0[i] == T) begin
          active[i] = 1'b0;
          mbtn[i]   = pred[i];
          gap[i]    = 0;
          mvld[i]   = 1'b1;
        end
      end else if (start_v[i] || (auto_v[i] && gap[i] == GAP)) begin
        active[i] = 1'b1;
        t0[i]     = cyc;
        pred[i]   = mask[i];
      end else if (gap[i] < GAP) begin
        gap[i]++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int T, r;
        logic el, ep, eb, ev;
        logic [15:0] ebt;
        T = 2 * H * (nbits(i) + 1);
        r = cyc - t0[i];
        el = 1'b0; ep = 1'b0; eb = 1'b0; ev = 1'b0; ebt = 16'h0;
        if (rst) begin
          eb  = active[i] && r >= 1 && r <= T;
          el  = active[i] && r <= 2 * H;
          ep  = active[i] && r > 2 * H && ((r - 2 * H - 1) % (2 * H)) >= H;
          ev  = mvld[i];
          ebt = mbtn[i];
        end
        chk($sformatf("latch%0d", i), lat_v[i], el);
        chk($sformatf("pclk%0d", i), pck_v[i], ep);
        chk($sformatf("busy%0d", i), bsy_v[i], eb);
        chk($sformatf("valid%0d", i), vld_v[i], ev);
        chk($sformatf("buttons%0d", i), btn_v[i], ebt);
      end
    end
  end

  // Shift-register pads: parallel-load while latch is high, advance on each pclk rise.
  initial begin
    int   pidx  [2];
    logic pprev [2];
    pidx = '{0, 0};
    pprev = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (lat_v[i]) pidx[i] = 0;
        else if (pck_v[i] && !pprev[i]) pidx[i]++;
        pprev[i] = pck_v[i];
        for (int p = 0; p < npads(i); p++) begin
          logic v;
          v = (pidx[i] < nbits(i)) ? ~mask[i][p * nbits(i) + pidx[i]] : 1'b0;
          if (i == 0) data_a[p] = v;
          else data_b[0] = v;
        end
      end
    end
  end

  task automatic observe(input int i, input int n, output int lp, output int lc, output int pp,
                         output int pc, output int nv, output int fv, output int sv);
    logic pl, pk;
    pl = 1'b0; pk = 1'b0;
    lp = 0; lc = 0; pp = 0; pc = 0; nv = 0; fv = -1; sv = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (lat_v[i] && !pl) lp++;
      if (lat_v[i]) lc++;
      if (pck_v[i] && !pk) pp++;
      if (pck_v[i]) pc++;
      if (vld_v[i]) begin
        nv++;
        if (fv < 0) fv = cyc;
        else if (sv < 0) sv = cyc;
      end
      pl = lat_v[i];
      pk = pck_v[i];
    end
  endtask

  // Raise i_start for one cycle (optionally again 'again' cycles later) while observing.
  task automatic go(input int i, input int n, input int again, output int ts, output int lp,
                    output int lc, output int pp, output int pc, output int nv, output int fv);
    int sv;
    @(posedge clk);
    #1;
    start_v[i] = 1'b1;
    ts = cyc;
    fork
      observe(i, n, lp, lc, pp, pc, nv, fv, sv);
      begin
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        if (again > 0) begin
          repeat (again - 1) @(posedge clk);
          #1 start_v[i] = 1'b1;
          @(posedge clk);
          #1 start_v[i] = 1'b0;
        end
      end
    join
  endtask

  initial begin
    int ts, lp, lc, pp, pc, nv, fv, sv;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b1;
    chk("reset_buttons", btn_v[0], 16'h0);
    chk("reset_strobes", {lat_v[0], pck_v[0], bsy_v[0], vld_v[0]}, 4'b0000);

    // Pad 0 presses A and Start: serial stream 0,1,1,0,1,1,1,1.
    mask[0] = 16'h0009;
    go(0, 45, 0, ts, lp, lc, pp, pc, nv, fv);
    chk("single_latency", fv - ts, 37);
    chk("single_buttons", btn_v[0], 16'h0009);
    chk("single_nvalid", nv, 1);

    // Reset during the first LOW half of a poll.
    mask[0] = 16'h1234;
    @(posedge clk);
    #1 start_v[0] = 1'b1;
    ts = cyc;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midpoll_busy", bsy_v[0], 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async_buttons", btn_v[0], 16'h0);
    chk("rst_async_strobes", {lat_v[0], pck_v[0], bsy_v[0], vld_v[0]}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Pad 0 releases everything, pad 1 presses everything.
    mask[0] = 16'hFF00;
    go(0, 45, 0, ts, lp, lc, pp, pc, nv, fv);
    chk("two_latency", fv - ts, 37);
    chk("two_buttons", btn_v[0], 16'hFF00);
    chk("two_latch_pulses", lp, 1);
    chk("two_latch_cycles", lc, 4);
    chk("two_pclk_pulses", pp, 8);
    chk("two_pclk_cycles", pc, 16);

    // Second start while busy must be dropped.
    mask[0] = 16'h3C5A;
    go(0, 60, 10, ts, lp, lc, pp, pc, nv, fv);
    chk("busy_latch_pulses", lp, 1);
    chk("busy_nvalid", nv, 1);
    chk("busy_latency", fv - ts, 37);
    chk("busy_buttons", btn_v[0], 16'h3C5A);

    // Auto mode, then disable in the middle of the third poll.
    mask[0] = 16'h0F0F;
    @(posedge clk);
    #1 auto_v[0] = 1'b1;
    observe(0, 100, lp, lc, pp, pc, nv, fv, sv);
    chk("auto_nvalid", nv, 2);
    chk("auto_spacing", sv - fv, 47);
    @(posedge clk);
    #1;
    chk("auto_midpoll_busy", bsy_v[0], 1'b1);
    auto_v[0] = 1'b0;
    observe(0, 100, lp, lc, pp, pc, nv, fv, sv);
    chk("auto_stop_nvalid", nv, 1);
    chk("auto_stop_latch", lp, 0);
    chk("auto_stop_buttons", btn_v[0], 16'h0F0F);

    // 16-bit pad, serial stream 0,1,0,1,...
    mask[1] = 16'h5555;
    go(1, 75, 0, ts, lp, lc, pp, pc, nv, fv);
    chk("snes_latency", fv - ts, 69);
    chk("snes_buttons", btn_v[1], 16'h5555);
    chk("snes_pclk_pulses", pp, 16);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
